// File: rtl/seg7_serial_driver.sv
// Serial 7-segment chain driver: builds an active-low frame, shifts it out MSB first, then latches it.
// Optional macro SEG7_BCD_EN adds a double-dabble converter for decimal display with an overflow flag.
module seg7_serial_driver #(
  parameter int DIGITS    = 8,
  parameter int SCLK_HALF = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] value,
  input  logic                dec_mode,
  input  logic [DIGITS-1:0]   dp,
  input  logic [DIGITS-1:0]   blank,
  output logic                seg_clk,
  output logic                seg_sout,
  output logic                SEG_PEN,
  output logic                seg_clrn,
  output logic                busy,
  output logic                done,
  output logic                ovf
);
  localparam int NBITS = 8 * DIGITS;
  localparam int VW    = 4 * DIGITS;
  localparam int PW    = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int BW    = $clog2(NBITS);
  localparam logic [PW-1:0] PHASE_LAST = PW'(SCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef SEG7_BCD_EN
    CONV  = 2'd1,
`endif
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  // Blank wins over the dash, which in turn suppresses glyph and dp.
  function automatic logic [NBITS-1:0] build_frame(input logic [VW-1:0] nib,
                                                   input logic [DIGITS-1:0] dpv,
                                                   input logic [DIGITS-1:0] blk,
                                                   input logic dash);
    logic [NBITS-1:0] f;
    f = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (blk[i])    f[8*i +: 8] = 8'hFF;
      else if (dash) f[8*i +: 8] = 8'hBF;
      else           f[8*i +: 8] = {~dpv[i], glyph(nib[4*i +: 4])};
    end
    return f;
  endfunction

  state_t            state, state_next;
  logic [PW-1:0]     phase;
  logic [BW-1:0]     bit_cnt;
  logic [NBITS-2:0]  shreg;
  logic [NBITS-1:0]  frame;
  logic              phase_end;

  assign phase_end = (phase == PHASE_LAST);
  assign busy      = (state != IDLE);
  assign seg_clrn  = rst;

`ifdef SEG7_BCD_EN
  function automatic logic [63:0] max_dec(input int n);
    logic [63:0] m;
    m = 64'd1;
    for (int i = 0; i < n; i++) m = m * 64'd10;
    return m - 64'd1;
  endfunction

  localparam int CW = $clog2(VW);
  localparam logic [CW-1:0] CONV_LAST = CW'(VW - 1);
  localparam logic [63:0]   MAX_DEC   = max_dec(DIGITS);

  logic [DIGITS-1:0] dp_q, blank_q, lead_blank;
  logic [VW-1:0]     bin_sr, bcd, bcd_fix, bcd_next;
  logic [CW-1:0]     conv_cnt;
  logic              ovf_q, lead, unused_bcd_top;

  assign ovf            = ovf_q;
  assign unused_bcd_top = bcd_fix[VW-1];

  always_comb begin
    bcd_fix = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_fix[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    bcd_next = {bcd_fix[VW-2:0], bin_sr[VW-1]};
  end

  // Zero digits above the first significant one go dark; digit 0 always shows.
  always_comb begin
    lead_blank = '0;
    lead       = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && bcd_next[4*i +: 4] == 4'd0) lead_blank[i] = 1'b1;
      else                                    lead = 1'b0;
    end
  end

  always_comb begin
    if (state == IDLE) frame = build_frame(value, dp, blank, 1'b0);
    else               frame = build_frame(bcd_next, dp_q, blank_q | (ovf_q ? '0 : lead_blank), ovf_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_q     <= '0;
      blank_q  <= '0;
      bin_sr   <= '0;
      bcd      <= '0;
      conv_cnt <= '0;
      ovf_q    <= 1'b0;
    end else if (state == IDLE && start) begin
      dp_q     <= dp;
      blank_q  <= blank;
      bin_sr   <= value;
      bcd      <= '0;
      conv_cnt <= '0;
      ovf_q    <= dec_mode && (64'(value) > MAX_DEC);
    end else if (state == CONV) begin
      bin_sr   <= {bin_sr[VW-2:0], 1'b0};
      bcd      <= bcd_next;
      conv_cnt <= conv_cnt + CW'(1);
    end
  end
`else
  logic unused_dec;
  assign unused_dec = dec_mode;
  assign ovf        = 1'b0;
  assign frame      = build_frame(value, dp, blank, 1'b0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef SEG7_BCD_EN
          state_next = dec_mode ? CONV : SHIFT;
`else
          state_next = SHIFT;
`endif
        end
      end
`ifdef SEG7_BCD_EN
      CONV:  if (conv_cnt == CONV_LAST) state_next = SHIFT;
`endif
      SHIFT: if (phase_end && seg_clk && bit_cnt == BIT_LAST) state_next = LATCH;
      LATCH: begin
        if (phase_end) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Data moves only on the falling half of seg_clk so it is settled a full half-period before each rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_clk  <= 1'b0;
      seg_sout <= 1'b1;
      SEG_PEN  <= 1'b0;
      shreg    <= '0;
      phase    <= '0;
      bit_cnt  <= '0;
    end else if (state != SHIFT && state_next == SHIFT) begin
      shreg    <= frame[NBITS-2:0];
      seg_sout <= frame[NBITS-1];
      seg_clk  <= 1'b0;
      SEG_PEN  <= 1'b0;
      phase    <= '0;
      bit_cnt  <= '0;
    end else if (state == SHIFT) begin
      if (phase_end) begin
        phase <= '0;
        if (!seg_clk) begin
          seg_clk <= 1'b1;
        end else begin
          seg_clk <= 1'b0;
          if (bit_cnt == BIT_LAST) begin
            SEG_PEN <= 1'b1;
          end else begin
            bit_cnt  <= bit_cnt + BW'(1);
            seg_sout <= shreg[NBITS-2];
            shreg    <= {shreg[NBITS-3:0], 1'b0};
          end
        end
      end else begin
        phase <= phase + PW'(1);
      end
    end else if (state == LATCH) begin
      phase <= phase_end ? '0 : phase + PW'(1);
    end
  end
endmodule

// File: tb/tb_seg7_serial_driver.sv
// Bench for seg7_serial_driver: frames are rebuilt off the serial pins and scoreboarded against a model.
module tb_seg7_serial_driver;
  localparam int DIGITS    = 8;
  localparam int SCLK_HALF = 2;
  localparam int HEX_BUSY  = 64 * 4 + 2;
  localparam int DEC_BUSY  = 32 + HEX_BUSY;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        dec_mode = 1'b0;
  logic [31:0] value = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  blank = '0;
  logic        seg_clk, seg_sout, SEG_PEN, seg_clrn, busy, done, ovf;

  always #5 clk = ~clk;

  seg7_serial_driver #(.DIGITS(DIGITS), .SCLK_HALF(SCLK_HALF)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .dec_mode(dec_mode),
    .dp(dp), .blank(blank), .seg_clk(seg_clk), .seg_sout(seg_sout), .SEG_PEN(SEG_PEN),
    .seg_clrn(seg_clrn), .busy(busy), .done(done), .ovf(ovf)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] rx_q[$];
  int          rx_bits_q[$];
  int          pen_rises = 0;
  int          sout_violations = 0;
  int          bit_cnt = 0;
  int          stable = 0;
  logic [63:0] rx_acc = '0;
  logic        prev_sclk = 1'b0, prev_pen = 1'b0, prev_busy = 1'b0, prev_sout = 1'b1;

  logic [7:0] glyph_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [63:0] model_frame(input logic [31:0] v, input logic dm,
                                              input logic [7:0] d, input logic [7:0] b);
    logic [63:0]     f;
    logic [7:0]      byt;
    longint unsigned vv, p;
    bit              over;
    vv   = longint'(v);
    p    = 1;
    over = dm && (vv > 64'd99999999);
    for (int i = 0; i < 8; i++) begin
      if (b[i])      byt = 8'hFF;
      else if (over) byt = 8'hBF;
      else if (dm) begin
        if (i != 0 && vv < p) byt = 8'hFF;
        else                  byt = glyph_tbl[int'((vv / p) % 10)] & (d[i] ? 8'h7F : 8'hFF);
      end else begin
        byt = glyph_tbl[v[4*i +: 4]] & (d[i] ? 8'h7F : 8'hFF);
      end
      f[8*i +: 8] = byt;
      p = p * 10;
    end
    return f;
  endfunction

  // Pin-level monitor: rebuilds frames on seg_clk rises and files them when SEG_PEN rises.
  always @(negedge clk) begin
    if (!rst) begin
      bit_cnt   = 0;
      rx_acc    = '0;
      stable    = 0;
      prev_sclk = 1'b0;
      prev_pen  = 1'b0;
      prev_busy = 1'b0;
      prev_sout = 1'b1;
    end else begin
      if (busy && !prev_busy) begin
        bit_cnt = 0;
        rx_acc  = '0;
      end
      if (seg_sout !== prev_sout) begin
        stable = 0;
        if (seg_clk) sout_violations++;
      end else begin
        stable++;
      end
      if (seg_clk && !prev_sclk) begin
        if (stable < SCLK_HALF) sout_violations++;
        rx_acc = {rx_acc[62:0], seg_sout};
        bit_cnt++;
      end
      if (SEG_PEN && !prev_pen) begin
        pen_rises++;
        rx_q.push_back(rx_acc);
        rx_bits_q.push_back(bit_cnt);
      end
      prev_sclk = seg_clk;
      prev_pen  = SEG_PEN;
      prev_busy = busy;
      prev_sout = seg_sout;
    end
  end

  task automatic apply_stimulus(input logic [31:0] v, input logic dm, input logic [7:0] d,
                                input logic [7:0] b, input logic [63:0] expf);
    @(negedge clk);
    value = v; dec_mode = dm; dp = d; blank = b; start = 1'b1;
    exp_q.push_back(expf);
    @(negedge clk);
    start = 1'b0;
    value = $urandom; dp = 8'($urandom); blank = 8'($urandom); dec_mode = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int busy_cycles, output int done_pulses,
                           output bit timed_out);
    int cyc;
    cyc = 0; busy_cycles = 0; done_pulses = 0; timed_out = 1'b0;
    forever begin
      if (busy) busy_cycles++;
      if (done) begin done_pulses++; break; end
      if (cyc >= budget) begin timed_out = 1'b1; break; end
      @(negedge clk);
      cyc++;
    end
    repeat (3) begin
      @(negedge clk);
      if (done) done_pulses++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({seg_clk, seg_sout, SEG_PEN, seg_clrn, busy, done, ovf} !== 7'b0100000) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b, want 0100000", {seg_clk, seg_sout, SEG_PEN, seg_clrn, busy, done, ovf});
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({seg_clrn, busy, SEG_PEN} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got %b, want 100", {seg_clrn, busy, SEG_PEN});
    end
  endtask

  task automatic test_hex_frame();
    logic [63:0] want, got;
    int bc, dc, nb;
    bit to;
    apply_stimulus(32'h0123_ABCD, 1'b0, 8'h00, 8'h00, 64'hC0F9A4B0_8883C6A1);
    wait_done(2000, bc, dc, to);
    n_checks++;
    if (to) begin n_fail++; $display("[TB] FAIL hex_timeout: got no done, want done within 2000 cycles"); end
    want = exp_q.pop_front();
    n_checks++;
    if (rx_q.size() == 0) begin
      n_fail++; $display("[TB] FAIL hex_frame: got no frame, want %h", want);
    end else begin
      got = rx_q.pop_front(); nb = rx_bits_q.pop_front();
      if (got !== want) begin n_fail++; $display("[TB] FAIL hex_frame: got %h, want %h", got, want); end
      n_checks++;
      if (nb !== 64) begin n_fail++; $display("[TB] FAIL hex_bits: got %0d, want 64", nb); end
    end
    n_checks++;
    if (bc !== HEX_BUSY) begin n_fail++; $display("[TB] FAIL hex_busy_cycles: got %0d, want %0d", bc, HEX_BUSY); end
    n_checks++;
    if (dc !== 1) begin n_fail++; $display("[TB] FAIL hex_done_pulses: got %0d, want 1", dc); end
    n_checks++;
    if ({seg_clk, SEG_PEN, busy, ovf} !== 4'b0100) begin
      n_fail++; $display("[TB] FAIL hex_idle_pins: got %b, want 0100", {seg_clk, SEG_PEN, busy, ovf});
    end
    n_checks++;
    if (sout_violations !== 0) begin n_fail++; $display("[TB] FAIL sout_timing: got %0d violations, want 0", sout_violations); end
  endtask

  task automatic test_blank_dp();
    logic [63:0] want, got;
    int bc, dc, nb;
    bit to, bad;
    apply_stimulus(32'h89AB_CDEF, 1'b0, 8'hFF, 8'h81, model_frame(32'h89AB_CDEF, 1'b0, 8'hFF, 8'h81));
    wait_done(2000, bc, dc, to);
    n_checks++;
    if (to) begin n_fail++; $display("[TB] FAIL blank_timeout: got no done, want done within 2000 cycles"); end
    want = exp_q.pop_front();
    n_checks++;
    if (rx_q.size() == 0) begin
      n_fail++; $display("[TB] FAIL blank_frame: got no frame, want %h", want);
    end else begin
      got = rx_q.pop_front(); nb = rx_bits_q.pop_front();
      if (got !== want) begin n_fail++; $display("[TB] FAIL blank_frame: got %h, want %h", got, want); end
      bad = (got[63:56] !== 8'hFF) || (got[7:0] !== 8'hFF);
      for (int i = 1; i < 7; i++) if (got[8*i+7] !== 1'b0) bad = 1'b1;
      n_checks++;
      if (bad) begin n_fail++; $display("[TB] FAIL blank_dp_bits: got %h, want digits 7,0 FF and others bit7 0", got); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [63:0] want, got;
    int bc, dc, nb, pen0;
    bit to;
    pen0 = pen_rises;
    apply_stimulus(32'h5A5A_0F0F, 1'b0, 8'h10, 8'h00, model_frame(32'h5A5A_0F0F, 1'b0, 8'h10, 8'h00));
    repeat (40) @(negedge clk);
    value = 32'hFFFF_FFFF; blank = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000, bc, dc, to);
    repeat (10) @(negedge clk);
    n_checks++;
    if (to) begin n_fail++; $display("[TB] FAIL ignore_timeout: got no done, want done within 2000 cycles"); end
    want = exp_q.pop_front();
    n_checks++;
    if (rx_q.size() == 0) begin
      n_fail++; $display("[TB] FAIL ignore_frame: got no frame, want %h", want);
    end else begin
      got = rx_q.pop_front(); nb = rx_bits_q.pop_front();
      if (got !== want) begin n_fail++; $display("[TB] FAIL ignore_frame: got %h, want %h", got, want); end
    end
    n_checks++;
    if ((pen_rises - pen0) !== 1 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ignore_frame_count: got %0d frames busy=%b, want 1 frames busy=0", pen_rises - pen0, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] want, got;
    int bc, dc, nb, pen0, cyc;
    bit to;
    pen0 = pen_rises;
    apply_stimulus(32'h0123_ABCD, 1'b0, 8'h00, 8'h00, 64'hC0F9A4B0_8883C6A1);
    cyc = 0;
    while (bit_cnt < 20 && cyc < 1000) begin @(negedge clk); cyc++; end
    n_checks++;
    if (bit_cnt < 20) begin n_fail++; $display("[TB] FAIL abort_reach_bit20: got %0d bits, want 20", bit_cnt); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({seg_clk, seg_sout, SEG_PEN, seg_clrn, busy, done, ovf} !== 7'b0100000) begin
      n_fail++;
      $display("[TB] FAIL abort_async_outputs: got %b, want 0100000", {seg_clk, seg_sout, SEG_PEN, seg_clrn, busy, done, ovf});
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if ((pen_rises - pen0) !== 0) begin n_fail++; $display("[TB] FAIL abort_no_latch: got %0d latches, want 0", pen_rises - pen0); end
    void'(exp_q.pop_front());
    rst = 1'b1;
    @(negedge clk);
    apply_stimulus(32'hFEDC_0123, 1'b0, 8'h5A, 8'h00, model_frame(32'hFEDC_0123, 1'b0, 8'h5A, 8'h00));
    wait_done(2000, bc, dc, to);
    n_checks++;
    if (to) begin n_fail++; $display("[TB] FAIL abort_restart_timeout: got no done, want done within 2000 cycles"); end
    want = exp_q.pop_front();
    n_checks++;
    if (rx_q.size() == 0) begin
      n_fail++; $display("[TB] FAIL abort_restart_frame: got no frame, want %h", want);
    end else begin
      got = rx_q.pop_front(); nb = rx_bits_q.pop_front();
      if (got !== want) begin n_fail++; $display("[TB] FAIL abort_restart_frame: got %h, want %h", got, want); end
      n_checks++;
      if (nb !== 64) begin n_fail++; $display("[TB] FAIL abort_restart_bits: got %0d, want 64", nb); end
    end
  endtask

`ifdef SEG7_BCD_EN
  task automatic test_decimal();
    logic [63:0] want, got;
    int bc, dc, nb;
    bit to;
    apply_stimulus(32'd1234, 1'b1, 8'h00, 8'h00, 64'hFFFFFFFF_F9A4B099);
    wait_done(3000, bc, dc, to);
    n_checks++;
    if (to) begin n_fail++; $display("[TB] FAIL dec_timeout: got no done, want done within 3000 cycles"); end
    want = exp_q.pop_front();
    n_checks++;
    if (rx_q.size() == 0) begin
      n_fail++; $display("[TB] FAIL dec_frame: got no frame, want %h", want);
    end else begin
      got = rx_q.pop_front(); nb = rx_bits_q.pop_front();
      if (got !== want) begin n_fail++; $display("[TB] FAIL dec_frame: got %h, want %h", got, want); end
    end
    n_checks++;
    if (bc !== DEC_BUSY) begin n_fail++; $display("[TB] FAIL dec_busy_cycles: got %0d, want %0d", bc, DEC_BUSY); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL dec_ovf: got %b, want 0", ovf); end
    apply_stimulus(32'd0, 1'b1, 8'h00, 8'h00, model_frame(32'd0, 1'b1, 8'h00, 8'h00));
    wait_done(3000, bc, dc, to);
    want = exp_q.pop_front();
    n_checks++;
    if (rx_q.size() == 0) begin
      n_fail++; $display("[TB] FAIL dec_zero_frame: got no frame, want %h", want);
    end else begin
      got = rx_q.pop_front(); nb = rx_bits_q.pop_front();
      if (got !== want) begin n_fail++; $display("[TB] FAIL dec_zero_frame: got %h, want %h", got, want); end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] want, got;
    int bc, dc, nb;
    bit to;
    apply_stimulus(32'd100000000, 1'b1, 8'hFF, 8'h00, {8{8'hBF}});
    wait_done(3000, bc, dc, to);
    want = exp_q.pop_front();
    n_checks++;
    if (rx_q.size() == 0) begin
      n_fail++; $display("[TB] FAIL ovf_frame: got no frame, want %h", want);
    end else begin
      got = rx_q.pop_front(); nb = rx_bits_q.pop_front();
      if (got !== want) begin n_fail++; $display("[TB] FAIL ovf_frame: got %h, want %h", got, want); end
    end
    n_checks++;
    if (ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_set: got %b, want 1", ovf); end
    apply_stimulus(32'h1234_5678, 1'b0, 8'h00, 8'h00, model_frame(32'h1234_5678, 1'b0, 8'h00, 8'h00));
    wait_done(3000, bc, dc, to);
    want = exp_q.pop_front();
    if (rx_q.size() != 0) begin got = rx_q.pop_front(); nb = rx_bits_q.pop_front(); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_clear: got %b, want 0", ovf); end
  endtask
`else
  task automatic test_dec_ignored();
    logic [63:0] want, got;
    int bc, dc, nb;
    bit to;
    apply_stimulus(32'd1234, 1'b1, 8'h00, 8'h00, model_frame(32'd1234, 1'b0, 8'h00, 8'h00));
    wait_done(3000, bc, dc, to);
    want = exp_q.pop_front();
    n_checks++;
    if (rx_q.size() == 0) begin
      n_fail++; $display("[TB] FAIL decoff_frame: got no frame, want %h", want);
    end else begin
      got = rx_q.pop_front(); nb = rx_bits_q.pop_front();
      if (got !== want) begin n_fail++; $display("[TB] FAIL decoff_frame: got %h, want %h", got, want); end
    end
    n_checks++;
    if (bc !== HEX_BUSY || ovf !== 1'b0) begin
      n_fail++; $display("[TB] FAIL decoff_busy_ovf: got %0d/%b, want %0d/0", bc, ovf, HEX_BUSY);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, want finish before 500000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_hex_frame();
    test_blank_dp();
    test_busy_ignore();
    test_reset_mid_frame();
`ifdef SEG7_BCD_EN
    test_decimal();
    test_overflow();
`else
    test_dec_ignored();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
